// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the mem/wb stage and the data memory.
// One request is outstanding at a time; the master holds dm_req and every
// request field stable until the slave returns dm_ack. Read data is valid
// in the ack cycle.
//   master: dm_req, dm_we, dm_be, dm_addr, dm_wdata out; dm_ack, dm_rdata in
//   slave : the mirror image
interface mem_wb_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
                    input  dm_ack, dm_rdata);
    modport slave  (input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
                    output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage behind the registered ALU stage.
// Accepts one ALU result when idle, performs load/store through a
// single-outstanding data-memory handshake, and commits GPR, HI/LO and CP0
// writes, exceptions and branch-mispredict redirects. All outputs registered.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   ex_out_valid, alu_*  instruction from the ALU output registers
//   wb_allin             stage can accept an instruction this cycle
//   dm                   data-memory bus (master side)
//   rf_*, hi_we/lo_we/hilo_wdata, cp0_*   architectural write ports
//   redirect_*, flush_req, exc_*, eret_commit   control-flow outputs
//   retire_cnt           retired-instruction counter (wraps)
module mem_wb_stage (
    input  logic           clk,
    input  logic           reset,
    input  logic           ex_out_valid,
    input  logic [4:0]     alu_dest_addr,
    input  logic [31:0]    alu_pc,
    input  logic [5:0]     alu_op,
    input  logic [31:0]    alu_out,
    input  logic [31:0]    alu_out_wr,
    input  logic           alu_fu_ov,
    input  logic [4:0]     alu_exp_code,
    input  logic           alu_bp_result,
    output logic           wb_allin,
    mem_wb_stage_if.master dm,
    output logic           rf_we,
    output logic [4:0]     rf_waddr,
    output logic [31:0]    rf_wdata,
    output logic           hi_we,
    output logic           lo_we,
    output logic [31:0]    hilo_wdata,
    output logic           cp0_we,
    output logic [4:0]     cp0_waddr,
    output logic [31:0]    cp0_wdata,
    output logic           redirect_valid,
    output logic [31:0]    redirect_pc,
    output logic           flush_req,
    output logic           exc_valid,
    output logic [4:0]     exc_code,
    output logic [31:0]    exc_pc,
    output logic [31:0]    exc_badvaddr,
    output logic           eret_commit,
    output logic [31:0]    retire_cnt
);

    // Opcode encoding shared with the ALU stage.
    localparam logic [5:0] OP_ADD    = 6'd1,  OP_ADDI  = 6'd2,  OP_ADDU  = 6'd3,
                           OP_ADDIU  = 6'd4,  OP_SUB   = 6'd5,  OP_SUBU  = 6'd6,
                           OP_AND    = 6'd7,  OP_OR    = 6'd8,  OP_XOR   = 6'd9,
                           OP_NOR    = 6'd10, OP_SLL   = 6'd11, OP_SRL   = 6'd12,
                           OP_SRA    = 6'd13, OP_SLT   = 6'd14, OP_SLTU  = 6'd15,
                           OP_LUI    = 6'd16, OP_MFHI  = 6'd17, OP_MFLO  = 6'd18,
                           OP_MFC0   = 6'd19, OP_MTHI  = 6'd20, OP_MTLO  = 6'd21,
                           OP_MTC0   = 6'd22, OP_LB    = 6'd23, OP_LBU   = 6'd24,
                           OP_LH     = 6'd25, OP_LHU   = 6'd26, OP_LW    = 6'd27,
                           OP_SB     = 6'd28, OP_SH    = 6'd29, OP_SW    = 6'd30,
                           OP_BEQ    = 6'd31, OP_BNE   = 6'd32, OP_BGEZ  = 6'd33,
                           OP_BGTZ   = 6'd34, OP_BLEZ  = 6'd35, OP_BLTZ  = 6'd36,
                           OP_BGEZAL = 6'd37, OP_BLTZAL= 6'd38, OP_J     = 6'd39,
                           OP_JAL    = 6'd40, OP_JR    = 6'd41, OP_JALR  = 6'd42,
                           OP_ERET   = 6'd43, OP_ANDI  = 6'd45, OP_ORI   = 6'd46,
                           OP_XORI   = 6'd47, OP_SLTI  = 6'd48, OP_SLTIU = 6'd49,
                           OP_SLLV   = 6'd50, OP_SRLV  = 6'd51, OP_SRAV  = 6'd52;

    localparam logic [4:0] EXC_NO_EXC = 5'd0,
                           EXC_ADEL   = 5'd4,
                           EXC_ADES   = 5'd5,
                           EXC_OV     = 5'd12;

    typedef enum logic [0:0] {IDLE, MEM_WAIT} state_t;
    state_t state;

    // Decode of the incoming opcode.
    logic is_load, is_store, is_gpr, is_branch, is_ov_op, acc_half, acc_word;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_gpr    = 1'b0;
        is_branch = 1'b0;
        is_ov_op  = 1'b0;
        acc_half  = 1'b0;
        acc_word  = 1'b0;
        case (alu_op)
            OP_ADD, OP_ADDI, OP_SUB: begin
                is_gpr   = 1'b1;
                is_ov_op = 1'b1;
            end
            OP_ADDU, OP_ADDIU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_ANDI, OP_ORI, OP_XORI, OP_SLL, OP_SRL, OP_SRA, OP_SLLV,
            OP_SRLV, OP_SRAV, OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU, OP_LUI,
            OP_MFHI, OP_MFLO, OP_MFC0:
                is_gpr = 1'b1;
            OP_LB, OP_LBU:  is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load  = 1'b1;
                acc_half = 1'b1;
            end
            OP_LW: begin
                is_load  = 1'b1;
                acc_word = 1'b1;
            end
            OP_SB: is_store = 1'b1;
            OP_SH: begin
                is_store = 1'b1;
                acc_half = 1'b1;
            end
            OP_SW: begin
                is_store = 1'b1;
                acc_word = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGEZ, OP_BGTZ, OP_BLEZ, OP_BLTZ, OP_J, OP_JR,
            OP_ERET:
                is_branch = 1'b1;
            // Linking branches both write the link register and may redirect.
            OP_BGEZAL, OP_BLTZAL, OP_JAL, OP_JALR: begin
                is_branch = 1'b1;
                is_gpr    = 1'b1;
            end
            default: ;
        endcase
    end

    logic misaligned;
    assign misaligned = (acc_half && alu_out[0]) || (acc_word && (alu_out[1:0] != 2'b00));

    // Exception selection, highest priority first.
    logic        exc_hit;
    logic [4:0]  exc_sel;
    logic [31:0] exc_bad;

    always_comb begin
        exc_hit = 1'b1;
        exc_sel = alu_exp_code;
        exc_bad = 32'h0;
        if (alu_exp_code != EXC_NO_EXC) begin
            exc_sel = alu_exp_code;
        end else if (alu_fu_ov && is_ov_op) begin
            exc_sel = EXC_OV;
        end else if (is_load && misaligned) begin
            exc_sel = EXC_ADEL;
            exc_bad = alu_out;
        end else if (is_store && misaligned) begin
            exc_sel = EXC_ADES;
            exc_bad = alu_out;
        end else begin
            exc_hit = 1'b0;
            exc_sel = EXC_NO_EXC;
        end
    end

    // Store lane placement: narrow data is replicated across the word so the
    // byte enables alone pick the target lane.
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = alu_out_wr;
        case (alu_op)
            OP_SB: begin
                st_be    = 4'b0001 << alu_out[1:0];
                st_wdata = {4{alu_out_wr[7:0]}};
            end
            OP_SH: begin
                st_be    = alu_out[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{alu_out_wr[15:0]}};
            end
            default: ;
        endcase
    end

    // Load return path, using the access latched at issue.
    logic [5:0]  mem_op_q;
    logic [4:0]  mem_dest_q;
    logic [1:0]  mem_lo_q;
    logic        mem_load_q;
    logic [31:0] ld_shift, ld_ext;

    assign ld_shift = dm.dm_rdata >> {mem_lo_q, 3'b000};

    always_comb begin
        case (mem_op_q)
            OP_LB:   ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            OP_LBU:  ld_ext = {24'h0, ld_shift[7:0]};
            OP_LH:   ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            OP_LHU:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wb_allin       <= 1'b1;
            dm.dm_req      <= 1'b0;
            dm.dm_we       <= 1'b0;
            dm.dm_be       <= 4'h0;
            dm.dm_addr     <= 32'h0;
            dm.dm_wdata    <= 32'h0;
            rf_we          <= 1'b0;
            rf_waddr       <= 5'h0;
            rf_wdata       <= 32'h0;
            hi_we          <= 1'b0;
            lo_we          <= 1'b0;
            hilo_wdata     <= 32'h0;
            cp0_we         <= 1'b0;
            cp0_waddr      <= 5'h0;
            cp0_wdata      <= 32'h0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            flush_req      <= 1'b0;
            exc_valid      <= 1'b0;
            exc_code       <= 5'h0;
            exc_pc         <= 32'h0;
            exc_badvaddr   <= 32'h0;
            eret_commit    <= 1'b0;
            retire_cnt     <= 32'h0;
            mem_op_q       <= 6'h0;
            mem_dest_q     <= 5'h0;
            mem_lo_q       <= 2'h0;
            mem_load_q     <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            rf_we          <= 1'b0;
            hi_we          <= 1'b0;
            lo_we          <= 1'b0;
            cp0_we         <= 1'b0;
            redirect_valid <= 1'b0;
            flush_req      <= 1'b0;
            exc_valid      <= 1'b0;
            eret_commit    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_out_valid) begin
                        if (exc_hit) begin
                            exc_valid    <= 1'b1;
                            flush_req    <= 1'b1;
                            exc_code     <= exc_sel;
                            exc_pc       <= alu_pc;
                            exc_badvaddr <= exc_bad;
                        end else if (is_load || is_store) begin
                            dm.dm_req   <= 1'b1;
                            dm.dm_we    <= is_store;
                            dm.dm_be    <= is_store ? st_be : 4'b1111;
                            dm.dm_addr  <= {alu_out[31:2], 2'b00};
                            dm.dm_wdata <= is_store ? st_wdata : 32'h0;
                            mem_op_q    <= alu_op;
                            mem_dest_q  <= alu_dest_addr;
                            mem_lo_q    <= alu_out[1:0];
                            mem_load_q  <= is_load;
                            state       <= MEM_WAIT;
                            wb_allin    <= 1'b0;
                        end else begin
                            if (is_gpr) begin
                                rf_we    <= (alu_dest_addr != 5'd0);
                                rf_waddr <= alu_dest_addr;
                                rf_wdata <= alu_out;
                            end
                            if (alu_op == OP_MTHI) begin
                                hi_we      <= 1'b1;
                                hilo_wdata <= alu_out;
                            end
                            if (alu_op == OP_MTLO) begin
                                lo_we      <= 1'b1;
                                hilo_wdata <= alu_out;
                            end
                            if (alu_op == OP_MTC0) begin
                                cp0_we    <= 1'b1;
                                cp0_waddr <= alu_dest_addr;
                                cp0_wdata <= alu_out_wr;
                            end
                            if (is_branch && !alu_bp_result) begin
                                redirect_valid <= 1'b1;
                                flush_req      <= 1'b1;
                                redirect_pc    <= alu_out_wr;
                                eret_commit    <= (alu_op == OP_ERET);
                            end
                            retire_cnt <= retire_cnt + 32'd1;
                        end
                    end
                end
                MEM_WAIT: begin
                    // Request fields stay untouched until the ack.
                    if (dm.dm_ack) begin
                        dm.dm_req  <= 1'b0;
                        state      <= IDLE;
                        wb_allin   <= 1'b1;
                        retire_cnt <= retire_cnt + 32'd1;
                        if (mem_load_q) begin
                            rf_we    <= (mem_dest_q != 5'd0);
                            rf_waddr <= mem_dest_q;
                            rf_wdata <= ld_ext;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage directly downstream of the registered ALU stage. It consumes one ALU result per accepted instruction. Loads and stores go through a single-outstanding data-memory handshake, with load extension and alignment checks. The stage writes the register file, HI/LO and CP0, raises exceptions, and signals branch-mispredict redirects to the front end.

## Interface
- No parameters; widths come from the shared headers (`WordDataBus` = 32, `AluOpBus` = 6, `IsaExpBus` = 5).
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_out_valid  in  1  ALU output registers hold a new, unconsumed instruction this cycle
- alu_dest_addr  in  5  destination GPR, or CP0 register index for MTC0
- alu_pc  in  32  instruction PC
- alu_op  in  6  `INSN_*` opcode
- alu_out  in  32  result, or effective address for load/store
- alu_out_wr  in  32  store data (low bits valid) / branch target / MTC0 data
- alu_fu_ov  in  1  signed overflow
- alu_exp_code  in  5  upstream exception code
- alu_bp_result  in  1  1 = prediction correct
- wb_allin  out  1  stage can accept (feeds ALU handshake)
- dm_req, dm_we  out  1  data memory request / write
- dm_be  out  4  byte enables
- dm_addr, dm_wdata  out  32  word-aligned address ({addr[31:2],2'b00}), write data
- dm_ack  in  1  request completed (read data valid same cycle)
- dm_rdata  in  32  read data
- rf_we  out  1, rf_waddr  out  5, rf_wdata  out  32  GPR write port
- hi_we, lo_we  out  1; hilo_wdata  out  32
- cp0_we  out  1, cp0_waddr  out  5, cp0_wdata  out  32
- redirect_valid  out  1, redirect_pc  out  32  mispredict redirect
- flush_req  out  1  flush all younger stages
- exc_valid  out  1, exc_code  out  5, exc_pc  out  32, exc_badvaddr  out  32
- eret_commit  out  1
- retire_cnt  out  32  retired-instruction counter

## Operation
- FSM states: IDLE, MEM_WAIT. wb_allin = (state == IDLE).
- IDLE with ex_out_valid: instruction accepted. Exception check priority:
  1. alu_exp_code != `ISA_EXC_NO_EXC`: pass it through.
  2. alu_fu_ov with ADD/ADDI/SUB: `ISA_EXC_OV`.
  3. Misaligned load (LH/LHU addr[0]; LW addr[1:0] != 0): `ISA_EXC_ADEL`.
  4. Misaligned store (SH/SW, same rules): `ISA_EXC_ADES`.
- On exception: the next cycle pulses exc_valid and flush_req, with exc_pc = alu_pc and exc_badvaddr = alu_out (address errors only, else 0). No GPR/HI/LO/CP0/memory side effect. Stay IDLE.
- Load/store with no exception: latch op, address, dest and data, then enter MEM_WAIT with dm_req = 1.
- Store lanes:
  - SB: be = 1 << addr[1:0]; wdata = byte replicated to 4 lanes.
  - SH: be = 0011 or 1100 by addr[1]; wdata = halfword replicated.
  - SW: be = 1111.
- Loads: dm_we = 0, be = 1111.
- MEM_WAIT: dm_req and all dm_* outputs held stable until dm_ack.
  - On ack: return to IDLE.
  - For a load, register the GPR write, selecting the byte/halfword by addr[1:0] (little-endian). LB/LH sign-extend; LBU/LHU zero-extend.
- Non-memory ops write a GPR with alu_out. Covered ops: arithmetic, logic, shift, SLT*, LUI, MFHI/MFLO/MFC0, JAL/JALR/BGEZAL/BLTZAL (link = alu_out).
- rf_we is suppressed when dest == 0.
- MTHI/MTLO: hi_we/lo_we with alu_out. MTC0: cp0_we with cp0_waddr = dest and data = alu_out_wr.
- Branch/jump/ERET with alu_bp_result == 0: pulse redirect_valid and flush_req, with redirect_pc = alu_out_wr. ERET also pulses eret_commit.
- retire_cnt increments by 1 per non-excepting retirement (at the write/ack commit) and wraps at 2^32.
- dm_ack while IDLE is ignored.

## Timing
- All outputs are registered.
- Reset values: every pulse/enable and every data/address output = 0, retire_cnt = 0, state = IDLE. wb_allin = 1 the first cycle after reset.
- Non-memory op accepted at cycle N: its write/redirect/exception pulse appears for exactly one cycle, N+1.
- Memory op accepted at cycle N: dm_req = 1 from N+1 through the ack cycle M inclusive. dm_req drops at M+1; load rf_we pulses at M+1; wb_allin = 1 at M+1.
- An ack in the same cycle as the first request (M = N+1) is legal.
- wb_allin = 0 for cycles N+1..M. A new instruction may be accepted at M+1.
- Reset in MEM_WAIT: dm_req drops next cycle and no write occurs; a late ack is ignored.

## Test plan
- ADDU dest 5, alu_out 0x1234 -> rf_we = 1 for one cycle, waddr 5, wdata 0x1234, retire_cnt 0 -> 1.
- LB addr 0x103, dm_rdata 0x80FF_FFFF, ack after 3 wait cycles -> be 1111; dm_addr 0x100 held for 4 cycles; rf_wdata 0xFFFF_FF80; wb_allin low throughout.
- SH addr 0x202, data 0xABCD -> be 1100, wdata 0xABCD_ABCD, no rf_we. Then SW addr 0x201 -> exc_valid, code ADES, badvaddr 0x201, dm_req stays 0, flush_req = 1.
- ADD with alu_fu_ov = 1 and dest 3 -> exc code OV, no rf_we, retire_cnt unchanged. Repeat with alu_exp_code = SYSCALL and fu_ov = 1 -> code SYSCALL (priority).
- BEQ with bp_result = 0, out_wr 0x8000_0040 -> redirect_valid and flush_req one cycle, redirect_pc 0x8000_0040. JAL with bp_result = 1, dest 31, out 0x408 -> rf write only.
- Load issued, reset asserted in MEM_WAIT, then dm_ack -> dm_req 0 after reset, no rf_we, wb_allin = 1, retire_cnt = 0.
